madd_et_checker: RTL and testbench
==================================

# madd_et_checker

Sequential error-threshold checker for the 2-bit multiply-add cells (6 inputs, 4 outputs) that the approximation flow produces. It sits directly downstream of the approximate madd netlist. It sweeps all 64 input vectors into the approximate cell, samples the cell's 4-bit result, compares it against an internal exact golden model, and accumulates worst-case error, error count and summed absolute error. The verdict, `pass`, confirms in hardware that the synthesized approximation respects its error threshold.

## Interface

Parameters:
- `ET`, default 8: error threshold; pass iff max |exact − approx| ≤ ET (range 0..15).
- `SETTLE`, default 1: cycles each vector is held before sampling (range 1..15).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `abort` in 1: cancel the sweep in progress; ignored in IDLE/DONE.
- `vec_o` out 6: drives approx cell `in5..in0` (bit i → `in`i).
- `approx_i` in 4: approx cell `out3..out0` (bit i ← `out`i); combinational from `vec_o`.
- `busy` out 1: high in DRIVE/SAMPLE.
- `done` out 1: one-cycle pulse when the sweep completes.
- `max_err` out 4: largest absolute error seen.
- `err_count` out 7: number of vectors with nonzero error (0..64).
- `err_sum` out 10: sum of absolute errors (max 64·15 = 960).
- `pass` out 1: `max_err ≤ ET`; valid from `done` until the next `start`.

## Operation

- Operand mapping: a = {in1,in0}, b = {in3,in2}, c = {in5,in4}.
- Exact result = a·b + c; range 0..12; 4-bit, no overflow.
- Error: err = |exact − approx_i|, computed in 5-bit signed, magnitude truncated to 4 bits (max 15).
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
  - IDLE --start--> DRIVE. On this transition, clear vec and all stats, and set the settle counter to 0.
  - DRIVE: hold `vec_o`. After SETTLE cycles, go to SAMPLE.
  - SAMPLE: one cycle. Register err into stats:
    - max_err = max(max_err, err)
    - err_count += (err ≠ 0)
    - err_sum += err
  - Leaving SAMPLE: if vec = 63, go to DONE; otherwise increment vec and go to DRIVE.
  - DONE: one cycle, `done` = 1, `pass` updated; then go to IDLE.
- The vector counter is 6-bit, 0→63. Wrap-around is never reached, because the sweep ends at 63.
- `abort` in DRIVE/SAMPLE: go to IDLE next cycle. Stats and `pass` are cleared to 0 and no `done` is issued. A SAMPLE coinciding with `abort` is discarded.
- `start` while busy or in DONE: ignored. `start` and `abort` together in IDLE: start wins.
- Stats and `pass` hold their values in IDLE until the next `start` or `rst`.

## Timing

- Reset values: state IDLE; `vec_o`=0, `busy`=0, `done`=0, `max_err`=0, `err_count`=0, `err_sum`=0, `pass`=0.
- `rst` mid-sweep returns every output to its reset value on the next edge and takes priority over all inputs.
- `start` sampled at edge E0 means:
  - Vector v is driven during cycles E0+v·(SETTLE+1) … +SETTLE−1.
  - Vector v is sampled in cycle E0+v·(SETTLE+1)+SETTLE.
  - `done` is high in cycle E0+64·(SETTLE+1).
  - Default sweep length: 128 cycles, plus 1 DONE cycle.
- `vec_o` is registered. `approx_i` must settle within SETTLE cycles; the bench models it as combinational.
- Stats outputs are registered and update on the edge ending each SAMPLE cycle.

## Structure

- Package `madd_chk_pkg`:
  - state enum
  - width constants VEC_W=6, RES_W=4, CNT_W=7, SUM_W=10
  - function `madd_exact(vec)` returning a·b+c
- Sub-module `madd_exact_ref`: combinational golden model (6 in → 4 out) wrapping the package function, so the bench can reuse it.
- Top contains the FSM, the counters and the stats datapath.

## Test plan

- approx_i = exact (golden loopback), default params: `done` at E0+128; max_err=0, err_count=0, err_sum=0, pass=1.
- approx_i = 0 constant: max_err=12, err_count=57, err_sum=240, pass=0.
- approx_i = exact ^ 4'b0001: max_err=1, err_count=64, err_sum=64, pass=1.
- approx_i = exact except vec 63 returns 4 (err 8): with ET=8, pass=1, max_err=8, err_count=1; same stimulus with ET=7 gives pass=0.
- `abort` at vec 20 → IDLE next cycle, no `done`, stats 0. A `start` pulse during the busy sweep is ignored (`done` time unchanged).
- `rst` asserted at vec 40 → all outputs at reset values next edge. A following `start` completes a full sweep normally.

Source files
------------

// File: rtl/madd_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : madd_chk_pkg
//  Purpose  : Shared types, widths and exact 2-bit multiply-add model for the
//             madd error-threshold checker.
//  Revision : 1.0  initial release
// ============================================================================
package madd_chk_pkg;

   localparam int VEC_W = 6;
   localparam int RES_W = 4;
   localparam int CNT_W = 7;
   localparam int SUM_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // a = vec[1:0], b = vec[3:2], c = vec[5:4]; result tops out at 12.
   function automatic logic [RES_W-1:0] madd_exact(input logic [VEC_W-1:0] vec);
      logic [RES_W-1:0] a;
      logic [RES_W-1:0] b;
      logic [RES_W-1:0] c;
      a = {2'b00, vec[1:0]};
      b = {2'b00, vec[3:2]};
      c = {2'b00, vec[5:4]};
      return (a * b) + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/madd_exact_ref.sv
`default_nettype none
// ============================================================================
//  Module   : madd_exact_ref
//  Purpose  : Combinational golden 2-bit multiply-add (6 in -> 4 out).
//  Revision : 1.0  initial release
// ============================================================================
module madd_exact_ref
   import madd_chk_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic [RES_W-1:0] exact
);

   assign exact = madd_exact(vec);

endmodule
`default_nettype wire

// File: rtl/madd_et_checker.sv
`default_nettype none
// ============================================================================
//  Module   : madd_et_checker
//  Purpose  : Sweeps all 64 vectors through an approximate madd cell and
//             accumulates max / count / sum of absolute error vs. exact.
//  Revision : 1.0  initial release
// ============================================================================
module madd_et_checker
   import madd_chk_pkg::*;
#(
   parameter int ET     = 8,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [VEC_W-1:0] vec_o,
   input  logic [RES_W-1:0] approx_i,
   output logic             busy,
   output logic             done,
   output logic [RES_W-1:0] max_err,
   output logic [CNT_W-1:0] err_count,
   output logic [SUM_W-1:0] err_sum,
   output logic             pass
);

   localparam logic [RES_W-1:0] c_ET          = RES_W'(ET);
   localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [VEC_W-1:0] c_VEC_LAST    = '1;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [VEC_W-1:0]        r_vec;
   logic [3:0]              r_settle;
   logic [RES_W-1:0]        r_max_err;
   logic [CNT_W-1:0]        r_err_count;
   logic [SUM_W-1:0]        r_err_sum;
   logic                    r_pass;

   logic                    w_begin;
   logic                    w_cancel;
   logic                    w_sample;
   logic [RES_W-1:0]        w_exact;
   logic signed [RES_W:0]   w_diff;
   logic [RES_W-1:0]        w_err;
   logic [RES_W-1:0]        w_max_next;

   madd_exact_ref u_exact_ref (
      .vec   (r_vec),
      .exact (w_exact)
   );

   // Difference in 5-bit signed; magnitude never exceeds 15 so 4 bits suffice.
   assign w_diff     = $signed({1'b0, w_exact}) - $signed({1'b0, approx_i});
   assign w_err      = w_diff[RES_W] ? RES_W'(-w_diff) : w_diff[RES_W-1:0];
   assign w_max_next = (w_err > r_max_err) ? w_err : r_max_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_begin      = 1'b0;
      w_cancel     = 1'b0;
      w_sample     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_DRIVE;
               w_begin      = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (abort) begin
               w_state_next = ST_IDLE;
               w_cancel     = 1'b1;
            end else if (r_settle == c_SETTLE_LAST) begin
               w_state_next = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               w_state_next = ST_IDLE;
               w_cancel     = 1'b1;
            end else begin
               w_sample     = 1'b1;
               w_state_next = (r_vec == c_VEC_LAST) ? ST_DONE : ST_DRIVE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || w_begin || w_cancel) begin
         r_vec       <= '0;
         r_settle    <= '0;
         r_max_err   <= '0;
         r_err_count <= '0;
         r_err_sum   <= '0;
         r_pass      <= 1'b0;
      end else begin
         if (r_state == ST_DRIVE) begin
            r_settle <= r_settle + 4'd1;
         end
         if (w_sample) begin
            r_settle    <= '0;
            r_max_err   <= w_max_next;
            r_err_count <= r_err_count + CNT_W'(w_err != '0);
            r_err_sum   <= r_err_sum + SUM_W'(w_err);
            // Verdict is registered on entry to DONE so it is valid with the pulse.
            if (r_vec == c_VEC_LAST) begin
               r_pass <= (w_max_next <= c_ET);
            end else begin
               r_vec <= r_vec + VEC_W'(1);
            end
         end
      end
   end

   assign vec_o     = r_vec;
   assign busy      = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
   assign done      = (r_state == ST_DONE);
   assign max_err   = r_max_err;
   assign err_count = r_err_count;
   assign err_sum   = r_err_sum;
   assign pass      = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_madd_et_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_madd_et_checker
//  Purpose  : Self-checking bench for madd_et_checker with an arithmetic
//             reference of the sweep statistics.
//  Revision : 1.0  initial release
// ============================================================================
module tb_madd_et_checker;

   localparam int S = 1;
   localparam int P = S + 1;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [5:0] vec1, vec2;
   logic [3:0] ap1, ap2;
   logic       busy1, busy2, done1, done2, pass1, pass2;
   logic [3:0] maxe1, maxe2;
   logic [6:0] cnt1, cnt2;
   logic [9:0] sum1, sum2;

   int         mode;
   logic [3:0] rnd_tbl [64];
   int         n_cmp = 0;
   int         n_mis = 0;

   madd_et_checker #(.ET(8), .SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .vec_o(vec1), .approx_i(ap1), .busy(busy1), .done(done1),
      .max_err(maxe1), .err_count(cnt1), .err_sum(sum1), .pass(pass1)
   );

   madd_et_checker #(.ET(7), .SETTLE(S)) dut7 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .vec_o(vec2), .approx_i(ap2), .busy(busy2), .done(done2),
      .max_err(maxe2), .err_count(cnt2), .err_sum(sum2), .pass(pass2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exact_of(input int v);
      return (v % 4) * ((v / 4) % 4) + (v / 16);
   endfunction

   function automatic logic [3:0] approx_of(input int m, input int v, input logic [3:0] r);
      int e;
      e = exact_of(v);
      case (m)
         0:       return 4'(e);
         1:       return 4'd0;
         2:       return 4'(e ^ 1);
         3:       return (v == 63) ? 4'd4 : 4'(e);
         default: return r;
      endcase
   endfunction

   assign ap1 = approx_of(mode, int'(vec1), rnd_tbl[vec1]);
   assign ap2 = approx_of(mode, int'(vec2), rnd_tbl[vec2]);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one full sweep; optionally pokes start mid-sweep to show it is ignored.
   task automatic sweep(input int m, input bit poke);
      int emax, ecnt, esum, got, v, d;
      mode = m;
      if (m == 4) begin
         for (int i = 0; i < 64; i++) rnd_tbl[i] = 4'($urandom_range(0, 15));
      end
      emax = 0; ecnt = 0; esum = 0; got = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (k == 0) begin
            check("first_vec", vec1, 0);
            check("busy_at_e0", busy1, 1);
         end
         if (k > 0 && (k % P) == 0 && k <= 64 * P) begin
            v = k / P - 1;
            d = exact_of(v) - int'(approx_of(m, v, rnd_tbl[v]));
            if (d < 0) d = -d;
            if (d > emax) emax = d;
            if (d != 0) ecnt++;
            esum += d;
            if (k < 64 * P) check("running_sum", sum1, esum);
         end
         if (done1) begin
            got = k;
            break;
         end
         if (poke && k == 50) start = 1'b1;
         if (poke && k == 51) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      check("done_cycle", got, 64 * P);
      check("max_err", maxe1, emax);
      check("err_count", cnt1, ecnt);
      check("err_sum", sum1, esum);
      check("pass_et8", pass1, (emax <= 8) ? 1 : 0);
      check("done_et7", done2, 1);
      check("pass_et7", pass2, (emax <= 7) ? 1 : 0);
      @(negedge clk);
      check("done_one_cycle", done1, 0);
      check("busy_after", busy1, 0);
      check("sum_held", sum1, esum);
      check("pass_held", pass1, (emax <= 8) ? 1 : 0);
      @(negedge clk);
   endtask

   initial begin
      int seen;
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
      for (int i = 0; i < 64; i++) rnd_tbl[i] = 4'd0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      check("rst_beats_start", busy1, 0);
      check("rst_vec", vec1, 0);
      check("rst_done", done1, 0);
      check("rst_stats", {maxe1, cnt1, sum1, pass1}, 0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);

      sweep(0, 1'b1);
      sweep(1, 1'b0);
      sweep(2, 1'b0);
      sweep(3, 1'b0);
      sweep(4, 1'b0);

      // Abort mid-sweep with errors already accumulated.
      mode = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 100 && vec1 != 6'd20; k++) @(negedge clk);
      check("reach_vec20", vec1, 20);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy1, 0);
      check("abort_done", done1, 0);
      check("abort_stats", {maxe1, cnt1, sum1, pass1}, 0);
      for (int k = 0; k < 150; k++) begin
         if (done1) seen++;
         @(negedge clk);
      end
      check("abort_no_done", seen, 0);

      // Synchronous reset mid-sweep.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 120 && vec1 != 6'd40; k++) @(negedge clk);
      check("reach_vec40", vec1, 40);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_vec", vec1, 0);
      check("midrst_busy", {busy1, busy2}, 0);
      check("midrst_done", done1, 0);
      check("midrst_stats", {maxe1, cnt1, sum1, pass1}, 0);
      @(negedge clk);

      sweep(4, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
